// File: rtl/packet_framer.sv
// Frames an unframed word stream into packets of PACKET_SIZE beats, tags each beat
// with a ping-pong bank bit, and buffers output through a two-entry skid buffer.
module packet_framer #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   PACKET_SIZE,
  input  logic [31:0]   PP_GROUP,
  input  logic [DW-1:0] S_AXIS_TDATA,
  input  logic          S_AXIS_TVALID,
  output logic          S_AXIS_TREADY,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TVALID,
  output logic          M_AXIS_TLAST,
  output logic          M_AXIS_TUSER,
  input  logic          M_AXIS_TREADY,
  output logic          PKT_DONE,
  output logic [31:0]   PKT_COUNT
);

  typedef enum logic {IDLE, RUN} state_t;

  // A configured count of zero behaves as a count of one.
  function automatic logic [31:0] at_least_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] size_q, size_d;
  logic [31:0] group_q, group_d;
  logic        bank_q, bank_d;
  logic [31:0] size_eff, group_eff;
  logic        s_xfer, m_xfer;
  logic        last_p0;

  logic          s_ready_q;
  logic          out_vld_p1, out_last_p1, out_user_p1;
  logic [DW-1:0] out_data_p1;
  logic          skid_vld_p1, skid_last_p1, skid_user_p1;
  logic [DW-1:0] skid_data_p1;
  logic          skid_vld_nxt;
  logic          pkt_done_q;
  logic [31:0]   pkt_count_q;

  assign s_xfer = S_AXIS_TVALID & s_ready_q;
  assign m_xfer = out_vld_p1 & M_AXIS_TREADY;

  // Stage p0: framing decisions made as each input word is accepted
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    size_d     = size_q;
    group_d    = group_q;
    bank_d     = bank_q;
    last_p0    = 1'b0;
    // In IDLE the live config is used so a one-beat packet closes on the latching edge.
    size_eff   = (state_q == IDLE) ? at_least_one(PACKET_SIZE) : size_q;
    group_eff  = (state_q == IDLE && pkt_cnt_q == 32'd0) ? at_least_one(PP_GROUP) : group_q;
    if (s_xfer) begin
      if (state_q == IDLE) begin
        size_d  = size_eff;
        group_d = group_eff;
      end
      last_p0 = (beat_cnt_q == size_eff - 32'd1);
      if (last_p0) begin
        beat_cnt_d = 32'd0;
        state_d    = IDLE;
        pkt_cnt_d  = pkt_cnt_q + 32'd1;
        if (pkt_cnt_q + 32'd1 == group_eff) begin
          pkt_cnt_d = 32'd0;
          bank_d    = ~bank_q;
        end
      end else begin
        beat_cnt_d = beat_cnt_q + 32'd1;
        state_d    = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= 32'd0;
      pkt_cnt_q  <= 32'd0;
      size_q     <= 32'd1;
      group_q    <= 32'd1;
      bank_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      size_q     <= size_d;
      group_q    <= group_d;
      bank_q     <= bank_d;
    end
  end

  // Stage p1: output register plus skid register
  assign skid_vld_nxt = skid_vld_p1 ? ~m_xfer : (s_xfer & out_vld_p1 & ~m_xfer);

  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready_q   <= 1'b0;
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
      out_last_p1 <= 1'b0;
      out_user_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_count_q <= 32'd0;
    end else begin
      s_ready_q   <= ~skid_vld_nxt;
      skid_vld_p1 <= skid_vld_nxt;
      pkt_done_q  <= m_xfer & out_last_p1;
      if (m_xfer && out_last_p1) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
      if (!out_vld_p1 || m_xfer) begin
        if (skid_vld_p1) begin
          out_vld_p1  <= 1'b1;
          out_data_p1 <= skid_data_p1;
          out_last_p1 <= skid_last_p1;
          out_user_p1 <= skid_user_p1;
        end else if (s_xfer) begin
          out_vld_p1  <= 1'b1;
          out_data_p1 <= S_AXIS_TDATA;
          out_last_p1 <= last_p0;
          out_user_p1 <= bank_q;
        end else begin
          out_vld_p1  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_xfer && out_vld_p1 && !m_xfer) begin
      skid_data_p1 <= S_AXIS_TDATA;
      skid_last_p1 <= last_p0;
      skid_user_p1 <= bank_q;
    end
  end

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TVALID = out_vld_p1;
  assign M_AXIS_TDATA  = out_data_p1;
  assign M_AXIS_TLAST  = out_last_p1;
  assign M_AXIS_TUSER  = out_user_p1;
  assign PKT_DONE      = pkt_done_q;
  assign PKT_COUNT     = pkt_count_q;

endmodule

// File: tb/tb_packet_framer.sv
// Scoreboard bench for packet_framer: a packet-level reference model fills an
// expectation queue on input acceptance; a negedge monitor pops and compares.
module tb_packet_framer;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   PACKET_SIZE = 32'd4;
  logic [31:0]   PP_GROUP = 32'd2;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic          S_AXIS_TVALID = 1'b0;
  logic          S_AXIS_TREADY;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER;
  logic          M_AXIS_TREADY = 1'b1;
  logic          PKT_DONE;
  logic [31:0]   PKT_COUNT;

  packet_framer #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .PACKET_SIZE(PACKET_SIZE), .PP_GROUP(PP_GROUP),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TREADY(M_AXIS_TREADY),
    .PKT_DONE(PKT_DONE), .PKT_COUNT(PKT_COUNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_tests = 0;
  int    n_fail = 0;

  logic        rst_q = 1'b1;
  logic        done_pend = 1'b0;
  logic [31:0] exp_cnt = 32'd0;
  int          done_seen = 0;
  logic        bp_mode = 1'b0;
  logic        tready_fixed = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference model: framing rules applied per accepted word
  logic [31:0] md_size = 32'd1, md_group = 32'd1, md_beat = 32'd0, md_pkt = 32'd0;
  logic        md_bank = 1'b0, md_open = 1'b0;
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      rst_q = reset;
      if (reset) begin
        exp_q.delete();
        md_beat = 32'd0; md_pkt = 32'd0; md_bank = 1'b0; md_open = 1'b0;
      end else if (S_AXIS_TVALID && S_AXIS_TREADY) begin
        if (!md_open) begin
          md_size = (PACKET_SIZE == 32'd0) ? 32'd1 : PACKET_SIZE;
          if (md_pkt == 32'd0) md_group = (PP_GROUP == 32'd0) ? 32'd1 : PP_GROUP;
          md_beat = 32'd0;
          md_open = 1'b1;
        end
        e.d = S_AXIS_TDATA;
        e.l = (md_beat == md_size - 32'd1);
        e.u = md_bank;
        exp_q.push_back(e);
        md_beat = md_beat + 32'd1;
        if (e.l) begin
          md_open = 1'b0;
          md_pkt = md_pkt + 32'd1;
          if (md_pkt == md_group) begin
            md_pkt = 32'd0;
            md_bank = ~md_bank;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      M_AXIS_TREADY = bp_mode ? ($urandom_range(0, 1) == 1) : tready_fixed;
    end
  end

  // Monitor: everything sampled at negedge describes the upcoming posedge
  initial begin
    beat_t e, held;
    logic  hold_prev;
    hold_prev = 1'b0;
    held.d = '0; held.l = 1'b0; held.u = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("rst_s_ready", 64'(S_AXIS_TREADY), 64'd0);
        chk("rst_m_valid", 64'(M_AXIS_TVALID), 64'd0);
        chk("rst_tlast", 64'(M_AXIS_TLAST), 64'd0);
        chk("rst_tuser", 64'(M_AXIS_TUSER), 64'd0);
        chk("rst_tdata", 64'(M_AXIS_TDATA), 64'd0);
        chk("rst_pkt_done", 64'(PKT_DONE), 64'd0);
        chk("rst_pkt_count", 64'(PKT_COUNT), 64'd0);
        done_pend = 1'b0;
        exp_cnt = 32'd0;
        hold_prev = 1'b0;
      end else begin
        chk("s_ready", 64'(S_AXIS_TREADY), 64'(exp_q.size() < 2));
        chk("m_valid", 64'(M_AXIS_TVALID), 64'(exp_q.size() > 0));
        chk("pkt_done", 64'(PKT_DONE), 64'(done_pend));
        chk("pkt_count", 64'(PKT_COUNT), 64'(exp_cnt));
        if (PKT_DONE) done_seen++;
        if (hold_prev) begin
          chk("stall_valid", 64'(M_AXIS_TVALID), 64'd1);
          chk("stall_data", 64'(M_AXIS_TDATA), 64'(held.d));
          chk("stall_last", 64'(M_AXIS_TLAST), 64'(held.l));
          chk("stall_user", 64'(M_AXIS_TUSER), 64'(held.u));
        end
        done_pend = 1'b0;
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 64'(M_AXIS_TDATA), 64'(e.d));
            chk("out_last", 64'(M_AXIS_TLAST), 64'(e.l));
            chk("out_user", 64'(M_AXIS_TUSER), 64'(e.u));
            if (e.l) begin
              done_pend = 1'b1;
              exp_cnt = exp_cnt + 32'd1;
            end
          end
          held.d = M_AXIS_TDATA; held.l = M_AXIS_TLAST; held.u = M_AXIS_TUSER;
          obs_q.push_back(held);
        end
        hold_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
        held.d = M_AXIS_TDATA; held.l = M_AXIS_TLAST; held.u = M_AXIS_TUSER;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int t;
    t = 0;
    S_AXIS_TDATA = d;
    S_AXIS_TVALID = 1'b1;
    while (!S_AXIS_TREADY && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) fail_now("s_accept_timeout");
    @(negedge clk);
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || M_AXIS_TVALID) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    S_AXIS_TVALID = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    done_seen = 0;
  endtask

  logic [DW-1:0] sent [100];

  initial begin
    @(negedge clk);

    // Basic framing
    do_reset();
    PACKET_SIZE = 32'd4; PP_GROUP = 32'd2;
    for (int i = 0; i < 16; i++) send(DW'(i));
    wait_drain();
    chk("basic_beats", 64'(obs_q.size()), 64'd16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      chk("basic_data", 64'(obs_q[i].d), 64'(i));
      chk("basic_last", 64'(obs_q[i].l), 64'(i % 4 == 3));
      chk("basic_user", 64'(obs_q[i].u), 64'((i / 8) % 2));
    end
    chk("basic_done_pulses", 64'(done_seen), 64'd4);
    chk("basic_pkt_count", 64'(PKT_COUNT), 64'd4);

    // Zero config behaves as one
    do_reset();
    PACKET_SIZE = 32'd0; PP_GROUP = 32'd0;
    for (int i = 0; i < 3; i++) send(DW'(32'hA0 + i));
    wait_drain();
    chk("zero_beats", 64'(obs_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      chk("zero_last", 64'(obs_q[i].l), 64'd1);
      chk("zero_user", 64'(obs_q[i].u), 64'(i % 2));
    end

    // Random backpressure
    do_reset();
    PACKET_SIZE = 32'd5; PP_GROUP = 32'd3;
    bp_mode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sent[i] = $urandom;
      send(sent[i]);
    end
    bp_mode = 1'b0;
    tready_fixed = 1'b1;
    wait_drain();
    chk("bp_beats", 64'(obs_q.size()), 64'd100);
    for (int i = 0; i < 100 && i < obs_q.size(); i++) begin
      chk("bp_data", 64'(obs_q[i].d), 64'(sent[i]));
      chk("bp_last", 64'(obs_q[i].l), 64'(i % 5 == 4));
    end
    chk("bp_pkt_count", 64'(PKT_COUNT), 64'd20);

    // Mid-packet and mid-group config changes
    do_reset();
    PACKET_SIZE = 32'd4; PP_GROUP = 32'd3;
    send(DW'(0));
    send(DW'(1));
    PACKET_SIZE = 32'd2; PP_GROUP = 32'd1;
    for (int i = 2; i < 12; i++) send(DW'(i));
    wait_drain();
    chk("cfg_beats", 64'(obs_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
      chk("cfg_last", 64'(obs_q[i].l), 64'(i == 3 || i == 5 || i == 7 || i == 9 || i == 11));
      chk("cfg_user", 64'(obs_q[i].u), 64'(i == 8 || i == 9));
    end

    // Reset with two words buffered mid-packet
    do_reset();
    PACKET_SIZE = 32'd4; PP_GROUP = 32'd2;
    tready_fixed = 1'b1;
    send(DW'(0));
    tready_fixed = 1'b0;
    send(DW'(1));
    send(DW'(2));
    chk("held_two_ready", 64'(S_AXIS_TREADY), 64'd0);
    tready_fixed = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) send(DW'(100 + i));
    wait_drain();
    chk("rst_beats", 64'(obs_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      chk("rst_data", 64'(obs_q[i].d), 64'(100 + i));
      chk("rst_last", 64'(obs_q[i].l), 64'(i == 3));
      chk("rst_user", 64'(obs_q[i].u), 64'd0);
    end
    chk("rst_pkt_count_after", 64'(PKT_COUNT), 64'd1);
    chk("rst_done_pulses", 64'(done_seen), 64'd1);

    // PKT_COUNT wrap
    @(posedge clk);
    #1;
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.pkt_count_q;
    @(negedge clk);
    done_seen = 0;
    for (int i = 0; i < 4; i++) send(DW'(200 + i));
    wait_drain();
    chk("wrap_pkt_count", 64'(PKT_COUNT), 64'd0);
    chk("wrap_done_pulses", 64'(done_seen), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
